// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART register block, the TX
// serializer and the top level.
//   lcr_t / fcr_t / lsr_t : 16550 register layouts (MSB first)
//   csr_t                 : register-block configuration bundle
//   div_t                 : baud divisor
//   tx_state_t            : transmit FSM states
//   tx_cfg_t              : per-frame line configuration latched at pop time
//   parity_bit()          : parity over the active word-length bits
package uart_pkg;

    typedef struct packed {
        logic       dlab;
        logic       set_break;
        logic       stick_parity;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    typedef struct packed {
        logic [1:0] rx_trig;
        logic [1:0] rsvd;
        logic       dma_mode;
        logic       tx_rst;
        logic       rx_rst;
        logic       fifo_en;
    } fcr_t;

    typedef struct packed {
        logic rx_fifo_err;
        logic temt;
        logic thre;
        logic bi;
        logic fe;
        logic pe;
        logic oe;
        logic dr;
    } lsr_t;

    typedef logic [15:0] div_t;

    typedef struct packed {
        lcr_t       lcr;
        fcr_t       fcr;
        logic [7:0] ier;
        logic [7:0] mcr;
        div_t       div;
    } csr_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       eps;
        logic       stick_parity;
    } tx_cfg_t;

    // Only the 5+wls low bits take part; upper bits of the byte are masked off.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic       eps,
                                        input logic       stick);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - wls);
        if (stick)
            return ~eps;
        else if (eps)
            return ^(data & mask);
        else
            return ~^(data & mask);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit shifter. Pops bytes from the TX FIFO and
// sends start, 5-8 data bits LSB first, optional parity and 1/1.5/2 stop bits,
// timed by the 16x baud pulse.
// Ports:
//   clk, rst          system clock, async active-high reset
//   baud_pulse_i      1-cycle oversample tick
//   lcr_i             line control (frame format + set_break)
//   tx_fifo_empty_i   TX FIFO empty flag
//   tx_fifo_dout_i    TX FIFO head (first-word-fall-through)
//   tx_pop_o          1-cycle pop strobe, issued on the baud pulse that loads a byte
//   tx_o              registered serial output, idle high
//   sreg_empty_o      1 while no frame is held or being sent
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse_i,
    input  lcr_t       lcr_i,
    input  logic       tx_fifo_empty_i,
    input  logic [7:0] tx_fifo_dout_i,
    output logic       tx_pop_o,
    output logic       tx_o,
    output logic       sreg_empty_o
);

    // Tick counter is wide enough to time a whole 2-stop period in one go,
    // so 1.5/2 stop bits need no extra sub-state.
    localparam int unsigned TW = $clog2(2 * OVERSAMPLE);
    typedef logic [TW-1:0] tick_t;

    localparam tick_t BIT_LAST    = tick_t'(OVERSAMPLE - 1);
    localparam tick_t STOP15_LAST = tick_t'(OVERSAMPLE * 3 / 2 - 1);
    localparam tick_t STOP2_LAST  = tick_t'(2 * OVERSAMPLE - 1);

    tx_state_t  state_q, state_d;
    tick_t      tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    tx_cfg_t    cfg_q, cfg_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       sreg_empty_q, sreg_empty_d;

    tick_t      tick_last;
    logic       bit_end;
    logic       load;
    logic       line_bit;
    logic [2:0] last_data_bit;
    logic       lcr_unused;

    assign lcr_unused    = lcr_i.dlab;
    assign last_data_bit = 3'd4 + {1'b0, cfg_q.wls};

    always_comb begin
        tick_last = BIT_LAST;
        if (state_q == STOP && cfg_q.stb)
            tick_last = (cfg_q.wls == 2'b00) ? STOP15_LAST : STOP2_LAST;
    end

    assign bit_end = baud_pulse_i && (tick_q == tick_last);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        cfg_d    = cfg_q;
        par_d    = par_q;
        load     = 1'b0;
        tx_pop_o = 1'b0;

        if (state_q != IDLE && baud_pulse_i)
            tick_d = bit_end ? '0 : tick_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (baud_pulse_i && !tx_fifo_empty_i)
                    load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == last_data_bit) begin
                        state_d = cfg_q.pen ? PARITY : STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end)
                    state_d = STOP;
            end
            STOP: begin
                // bit_end implies baud_pulse_i, so a non-empty FIFO here is a
                // valid pop condition: chain straight into the next start bit.
                if (bit_end) begin
                    if (!tx_fifo_empty_i)
                        load = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            tx_pop_o           = 1'b1;
            state_d            = START;
            tick_d             = '0;
            bit_d              = '0;
            shift_d            = tx_fifo_dout_i;
            cfg_d.wls          = lcr_i.wls;
            cfg_d.stb          = lcr_i.stb;
            cfg_d.pen          = lcr_i.pen;
            cfg_d.eps          = lcr_i.eps;
            cfg_d.stick_parity = lcr_i.stick_parity;
            par_d              = parity_bit(tx_fifo_dout_i, lcr_i.wls,
                                            lcr_i.eps, lcr_i.stick_parity);
        end
    end

    // Line level follows the next state so tx_o changes on the edge that ends a bit.
    always_comb begin
        case (state_d)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_d[0];
            PARITY:  line_bit = par_d;
            default: line_bit = 1'b1;
        endcase
        tx_d         = line_bit & ~lcr_i.set_break;
        sreg_empty_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            cfg_q        <= '0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            sreg_empty_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            cfg_q        <= cfg_d;
            par_q        <= par_d;
            tx_q         <= tx_d;
            sreg_empty_q <= sreg_empty_d;
        end
    end

    assign tx_o         = tx_q;
    assign sreg_empty_o = sreg_empty_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed bench for uart_tx_serializer. Baud pulse every
// 4 clocks (1 bit = 64 clk); a queue models the FWFT TX FIFO.
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic       baud_pulse_i;
    logic [7:0] lcr_i;
    logic       tx_fifo_empty_i;
    logic [7:0] tx_fifo_dout_i;
    logic       tx_pop_o;
    logic       tx_o;
    logic       sreg_empty_o;

    uart_tx_serializer #(.OVERSAMPLE(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .baud_pulse_i    (baud_pulse_i),
        .lcr_i           (lcr_i),
        .tx_fifo_empty_i (tx_fifo_empty_i),
        .tx_fifo_dout_i  (tx_fifo_dout_i),
        .tx_pop_o        (tx_pop_o),
        .tx_o            (tx_o),
        .sreg_empty_o    (sreg_empty_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pop_cnt  = 0;
    int last_pop = -10;
    logic [7:0] fifo_q[$];
    int pop_cyc_q[$];

    typedef struct {
        logic [7:0]  lcr;
        logic [7:0]  data;
        logic [15:0] bits;       // expected line level per slot, slot 0 = start
        int unsigned nslots;     // slots before the stop period
        int unsigned stop_ticks;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_pop(output int k, output bit ok);
        int n0;
        n0 = pop_cnt;
        ok = 1'b0;
        k  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pop_cnt > n0) begin
                ok = 1'b1;
                k  = last_pop;
                break;
            end
        end
        chk("pop_seen", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Baud generator + FIFO model; pop sampled mid-cycle before the edge it acts on.
    initial begin
        int bcnt;
        bcnt            = 0;
        baud_pulse_i    = 1'b0;
        tx_fifo_empty_i = 1'b1;
        tx_fifo_dout_i  = 8'h00;
        forever begin
            @(negedge clk);
            baud_pulse_i    = (bcnt == 3);
            bcnt            = (bcnt + 1) % 4;
            tx_fifo_empty_i = (fifo_q.size() == 0);
            tx_fifo_dout_i  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
            #2;
            if (tx_pop_o === 1'b1) begin
                chk("pop_while_empty", {31'd0, tx_fifo_empty_i}, 32'd0);
                chk("pop_width", {31'd0, (last_pop == cyc - 1)}, 32'd0);
                last_pop = cyc;
                pop_cyc_q.push_back(cyc);
                pop_cnt++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, e, n0, i0;
        bit ok;

        //          lcr    data   bits     nslots stop
        vecs[0] = '{8'h03, 8'h55, 16'h00AA,  9, 16};  // 8N1
        vecs[1] = '{8'h1A, 8'hC3, 16'h0186,  9, 16};  // 7E1, bit 7 ignored
        vecs[2] = '{8'h04, 8'h1F, 16'h003E,  6, 24};  // 5N1.5
        vecs[3] = '{8'h07, 8'hA5, 16'h014A,  9, 32};  // 8N2
        vecs[4] = '{8'h2B, 8'h00, 16'h0200, 10, 16};  // stick, eps=0 -> 1
        vecs[5] = '{8'h3B, 8'h00, 16'h0000, 10, 16};  // stick, eps=1 -> 0
        vecs[6] = '{8'h09, 8'hBF, 16'h00FE,  8, 16};  // 6O1, upper bits masked
        vecs[7] = '{8'h1C, 8'h0B, 16'h0056,  7, 24};  // 5E1.5
        vecs[8] = '{8'h03, 8'h00, 16'h0000,  9, 16};  // 8N1 all zero

        rst   = 1'b1;
        lcr_i = 8'h03;
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx_o}, 32'd1);
        chk("reset_pop", {31'd0, tx_pop_o}, 32'd0);
        chk("reset_sreg_empty", {31'd0, sreg_empty_o}, 32'd1);
        rst = 1'b0;

        // Empty FIFO: no pops, line idle.
        n0 = pop_cnt;
        at_cycle(cyc + 100);
        chk("idle_no_pop", pop_cnt - n0, 0);
        chk("idle_tx", {31'd0, tx_o}, 32'd1);
        chk("idle_sreg_empty", {31'd0, sreg_empty_o}, 32'd1);

        for (int v = 0; v < 9; v++) begin
            lcr_i = vecs[v].lcr;
            n0    = pop_cnt;
            fifo_q.push_back(vecs[v].data);
            wait_pop(k, ok);
            if (!ok) continue;
            lcr_i = 8'h00;  // mid-frame LCR change must not alter this frame
            for (int j = 0; j < int'(vecs[v].nslots); j++) begin
                at_cycle(k + 64 * j + 32);
                chk($sformatf("v%0d_slot%0d", v, j), {31'd0, tx_o},
                    {31'd0, vecs[v].bits[j]});
            end
            at_cycle(k + 64 * vecs[v].nslots + 32);
            chk($sformatf("v%0d_stop_mid", v), {31'd0, tx_o}, 32'd1);
            e = k + 64 * vecs[v].nslots + 4 * vecs[v].stop_ticks;
            at_cycle(e);
            chk($sformatf("v%0d_stop_last_tx", v), {31'd0, tx_o}, 32'd1);
            chk($sformatf("v%0d_stop_last_busy", v), {31'd0, sreg_empty_o}, 32'd0);
            at_cycle(e + 1);
            chk($sformatf("v%0d_done_empty", v), {31'd0, sreg_empty_o}, 32'd1);
            chk($sformatf("v%0d_pop_count", v), pop_cnt - n0, 1);
        end

        // Three queued bytes: back-to-back frames, pops exactly 640 clk apart.
        lcr_i = 8'h03;
        n0    = pop_cnt;
        i0    = pop_cyc_q.size();
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        wait_pop(k, ok);
        if (ok) begin
            at_cycle(k + 641);
            chk("b2b_no_idle_sreg", {31'd0, sreg_empty_o}, 32'd0);
            at_cycle(k + 640 + 32);
            chk("b2b_start2", {31'd0, tx_o}, 32'd0);
            at_cycle(k + 1280 + 32);
            chk("b2b_start3", {31'd0, tx_o}, 32'd0);
            at_cycle(k + 1920 + 1);
            chk("b2b_pop_count", pop_cnt - n0, 3);
            chk("b2b_done_empty", {31'd0, sreg_empty_o}, 32'd1);
            if (pop_cyc_q.size() >= i0 + 3) begin
                chk("b2b_gap1", pop_cyc_q[i0 + 1] - pop_cyc_q[i0], 640);
                chk("b2b_gap2", pop_cyc_q[i0 + 2] - pop_cyc_q[i0 + 1], 640);
            end else begin
                chk("b2b_pop_queue", pop_cyc_q.size() - i0, 3);
            end
        end

        // Break pulsed during DATA: line low while set, frame length unchanged.
        lcr_i = 8'h03;
        fifo_q.push_back(8'hFF);
        wait_pop(k, ok);
        if (ok) begin
            at_cycle(k + 64 * 3 + 10);
            chk("brk_before", {31'd0, tx_o}, 32'd1);
            lcr_i = 8'h43;
            at_cycle(k + 64 * 3 + 11);
            chk("brk_forced_low", {31'd0, tx_o}, 32'd0);
            at_cycle(k + 64 * 5 + 20);
            chk("brk_still_low", {31'd0, tx_o}, 32'd0);
            lcr_i = 8'h03;
            at_cycle(k + 64 * 5 + 21);
            chk("brk_released", {31'd0, tx_o}, 32'd1);
            at_cycle(k + 640);
            chk("brk_len_busy", {31'd0, sreg_empty_o}, 32'd0);
            at_cycle(k + 641);
            chk("brk_len_done", {31'd0, sreg_empty_o}, 32'd1);
        end

        // Async reset mid-frame: line high at once, frame dropped.
        fifo_q.push_back(8'h00);
        wait_pop(k, ok);
        if (ok) begin
            at_cycle(k + 64 * 2 + 32);
            chk("rst_pre_tx", {31'd0, tx_o}, 32'd0);
            #1 rst = 1'b1;
            #1;
            chk("rst_async_tx", {31'd0, tx_o}, 32'd1);
            chk("rst_async_sreg", {31'd0, sreg_empty_o}, 32'd1);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            n0  = pop_cnt;
            at_cycle(cyc + 700);
            chk("rst_after_tx", {31'd0, tx_o}, 32'd1);
            chk("rst_after_sreg", {31'd0, sreg_empty_o}, 32'd1);
            chk("rst_after_no_pop", pop_cnt - n0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
